// File: rtl/axi2mem_wr_cmd_seq.sv
// AXI write-burst command sequencer: expands one AW burst into per-beat TCDM
// word commands and returns end-of-burst synchronisation pulses as B responses.
module axi2mem_wr_cmd_seq #(
    parameter int ID_WIDTH = 6,
    parameter int B_DEPTH  = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                aw_valid_i,
    output logic                aw_ready_o,
    input  logic [31:0]         aw_addr_i,
    input  logic [7:0]          aw_len_i,
    input  logic [2:0]          aw_size_i,
    input  logic [1:0]          aw_burst_i,
    input  logic [ID_WIDTH-1:0] aw_id_i,
    output logic                trans_req_o,
    input  logic                trans_gnt_i,
    output logic [31:0]         trans_add_o,
    output logic [ID_WIDTH-1:0] trans_id_o,
    output logic                trans_last_o,
    input  logic                synch_req_i,
    input  logic [ID_WIDTH-1:0] synch_id_i,
    output logic                b_valid_o,
    input  logic                b_ready_i,
    output logic [ID_WIDTH-1:0] b_id_o,
    output logic [1:0]          b_resp_o
);
    localparam int CW = $clog2(B_DEPTH + 1);
    localparam int PW = (B_DEPTH > 1) ? $clog2(B_DEPTH) : 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t              state_reg, state_next;
    logic [31:0]         cur_addr_reg, cur_addr_next;
    logic [7:0]          len_reg, len_next;
    logic [7:0]          beat_cnt_reg, beat_cnt_next;
    logic [2:0]          size_reg, size_next;
    logic [1:0]          burst_reg, burst_next;
    logic [ID_WIDTH-1:0] id_reg, id_next;
    logic [CW-1:0]       outstanding_reg, outstanding_next;

    logic                aw_ready;
    logic                aw_hs;
    logic                b_hs;
    logic                last_beat;
    logic [31:0]         inc;
    logic [31:0]         aligned;
    logic [31:0]         incr_addr;
    logic [31:0]         wrap_size;
    logic [31:0]         adv_addr;

    logic [ID_WIDTH-1:0] fifo_mem [B_DEPTH];
    logic [PW-1:0]       wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]       count_reg;
    logic                push, pop;

    assign last_beat = (beat_cnt_reg == len_reg);

    // Next beat address: FIXED holds, INCR aligns then steps, WRAP folds back
    // to the wrap-window base once the step crosses the window boundary.
    always_comb begin
        inc       = 32'd1 << size_reg;
        aligned   = cur_addr_reg & ~(inc - 32'd1);
        incr_addr = aligned + inc;
        wrap_size = ({24'd0, len_reg} + 32'd1) << size_reg;
        adv_addr  = incr_addr;
        case (burst_reg)
            2'b00: adv_addr = cur_addr_reg;
            2'b10: begin
                if ((incr_addr & (wrap_size - 32'd1)) == 32'd0) begin
                    adv_addr = incr_addr - wrap_size;
                end
            end
            default: adv_addr = incr_addr;
        endcase
    end

    always_comb begin
        state_next    = state_reg;
        cur_addr_next = cur_addr_reg;
        len_next      = len_reg;
        beat_cnt_next = beat_cnt_reg;
        size_next     = size_reg;
        burst_next    = burst_reg;
        id_next       = id_reg;
        aw_ready      = 1'b0;
        trans_req_o   = 1'b0;
        case (state_reg)
            IDLE: begin
                // Gated by rst_i so nothing is accepted while reset is held.
                aw_ready = (outstanding_reg < CW'(B_DEPTH)) && !rst_i;
                if (aw_valid_i && aw_ready) begin
                    cur_addr_next = aw_addr_i;
                    len_next      = aw_len_i;
                    size_next     = aw_size_i;
                    burst_next    = aw_burst_i;
                    id_next       = aw_id_i;
                    beat_cnt_next = 8'd0;
                    state_next    = BURST;
                end
            end
            BURST: begin
                trans_req_o = 1'b1;
                if (trans_gnt_i) begin
                    if (last_beat) begin
                        state_next = IDLE;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + 8'd1;
                        cur_addr_next = adv_addr;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign aw_ready_o   = aw_ready;
    assign aw_hs        = aw_valid_i && aw_ready;
    assign trans_add_o  = cur_addr_reg;
    assign trans_id_o   = id_reg;
    assign trans_last_o = (state_reg == BURST) && last_beat;

    always_comb begin
        outstanding_next = outstanding_reg;
        case ({aw_hs, b_hs})
            2'b10:   outstanding_next = outstanding_reg + CW'(1);
            2'b01:   outstanding_next = outstanding_reg - CW'(1);
            default: outstanding_next = outstanding_reg;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg       <= IDLE;
            cur_addr_reg    <= 32'd0;
            len_reg         <= 8'd0;
            beat_cnt_reg    <= 8'd0;
            size_reg        <= 3'd0;
            burst_reg       <= 2'd0;
            id_reg          <= '0;
            outstanding_reg <= '0;
        end else begin
            state_reg       <= state_next;
            cur_addr_reg    <= cur_addr_next;
            len_reg         <= len_next;
            beat_cnt_reg    <= beat_cnt_next;
            size_reg        <= size_next;
            burst_reg       <= burst_next;
            id_reg          <= id_next;
            outstanding_reg <= outstanding_next;
        end
    end

    // Response FIFO; the outstanding limit guarantees a push never meets a full FIFO.
    assign push      = synch_req_i;
    assign pop       = b_hs;
    assign b_valid_o = (count_reg != '0);
    assign b_hs      = b_valid_o && b_ready_i;
    assign b_id_o    = fifo_mem[rd_ptr_reg];
    assign b_resp_o  = 2'b00;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < B_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_reg] <= synch_id_i;
                wr_ptr_reg <= (wr_ptr_reg == PW'(B_DEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PW'(B_DEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CW'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_axi2mem_wr_cmd_seq.sv
// Bench for axi2mem_wr_cmd_seq: queue-based burst/response model checked every
// cycle, directed bursts with literal address expectations, then random traffic.
module tb_axi2mem_wr_cmd_seq;
    localparam int ID_WIDTH = 6;
    localparam int B_DEPTH  = 2;

    logic                clk_i = 1'b0;
    logic                rst_i = 1'b0;
    logic                aw_valid_i = 1'b0;
    logic                aw_ready_o;
    logic [31:0]         aw_addr_i = '0;
    logic [7:0]          aw_len_i = '0;
    logic [2:0]          aw_size_i = '0;
    logic [1:0]          aw_burst_i = '0;
    logic [ID_WIDTH-1:0] aw_id_i = '0;
    logic                trans_req_o;
    logic                trans_gnt_i = 1'b0;
    logic [31:0]         trans_add_o;
    logic [ID_WIDTH-1:0] trans_id_o;
    logic                trans_last_o;
    logic                synch_req_i = 1'b0;
    logic [ID_WIDTH-1:0] synch_id_i = '0;
    logic                b_valid_o;
    logic                b_ready_i = 1'b0;
    logic [ID_WIDTH-1:0] b_id_o;
    logic [1:0]          b_resp_o;

    axi2mem_wr_cmd_seq #(.ID_WIDTH(ID_WIDTH), .B_DEPTH(B_DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_addr_i(aw_addr_i),
        .aw_len_i(aw_len_i), .aw_size_i(aw_size_i), .aw_burst_i(aw_burst_i), .aw_id_i(aw_id_i),
        .trans_req_o(trans_req_o), .trans_gnt_i(trans_gnt_i), .trans_add_o(trans_add_o),
        .trans_id_o(trans_id_o), .trans_last_o(trans_last_o),
        .synch_req_i(synch_req_i), .synch_id_i(synch_id_i),
        .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0]         addr;
        logic [ID_WIDTH-1:0] id;
        logic                last;
    } beat_t;

    beat_t               exp_beats[$];
    logic [ID_WIDTH-1:0] exp_b[$];
    logic [ID_WIDTH-1:0] synch_pending[$];
    logic [31:0]         log_addr[$];
    logic                log_last[$];
    int                  log_cyc[$];
    int                  out_cnt = 0;
    int                  errors = 0;
    int                  checks = 0;
    int                  cyc = 0;
    logic                hs_pending = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Address of beat k in closed form, straight from the AXI burst rules.
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len,
                                              input int size, input logic [1:0] burst, input int k);
        logic [31:0] inc, aligned, w, base;
        inc     = 32'd1 << size;
        aligned = a & ~(inc - 32'd1);
        if (k == 0 || burst == 2'b00) return a;
        if (burst == 2'b10) begin
            w    = 32'(len + 1) * inc;
            base = a & ~(w - 32'd1);
            return base + ((aligned - base + 32'(k) * inc) % w);
        end
        return aligned + 32'(k) * inc;
    endfunction

    always @(negedge clk_i) begin : compare
        logic  exp_ready;
        beat_t nb;
        cyc++;
        if (rst_i) begin
            check("rst_aw_ready", aw_ready_o, 0);
            check("rst_trans_req", trans_req_o, 0);
            check("rst_trans_last", trans_last_o, 0);
            check("rst_trans_add", trans_add_o, 0);
            check("rst_trans_id", trans_id_o, 0);
            check("rst_b_valid", b_valid_o, 0);
            check("rst_b_id", b_id_o, 0);
            check("rst_b_resp", b_resp_o, 0);
            exp_beats.delete();
            exp_b.delete();
            synch_pending.delete();
            out_cnt    = 0;
            hs_pending = 1'b0;
        end else begin
            exp_ready = (exp_beats.size() == 0) && (out_cnt < B_DEPTH);
            check("aw_ready", aw_ready_o, exp_ready);
            check("trans_req", trans_req_o, exp_beats.size() != 0);
            if (exp_beats.size() != 0) begin
                check("trans_add", trans_add_o, exp_beats[0].addr);
                check("trans_id", trans_id_o, exp_beats[0].id);
                check("trans_last", trans_last_o, exp_beats[0].last);
            end
            check("b_valid", b_valid_o, exp_b.size() != 0);
            if (exp_b.size() != 0) check("b_id", b_id_o, exp_b[0]);
            check("b_resp", b_resp_o, 0);

            hs_pending = aw_valid_i && aw_ready_o;
            if (exp_beats.size() != 0 && trans_gnt_i) begin
                log_addr.push_back(trans_add_o);
                log_last.push_back(trans_last_o);
                log_cyc.push_back(cyc);
                if (exp_beats[0].last) synch_pending.push_back(exp_beats[0].id);
                void'(exp_beats.pop_front());
            end
            if (b_ready_i && exp_b.size() != 0) begin
                void'(exp_b.pop_front());
                out_cnt--;
            end
            if (synch_req_i) begin
                check("fifo_room", exp_b.size() < B_DEPTH, 1);
                exp_b.push_back(synch_id_i);
            end
            if (aw_valid_i && exp_ready) begin
                out_cnt++;
                $display("aw id=%0d addr=0x%08h len=%0d size=%0d burst=%0d",
                         aw_id_i, aw_addr_i, aw_len_i, aw_size_i, aw_burst_i);
                for (int k = 0; k <= int'(aw_len_i); k++) begin
                    nb.addr = beat_addr(aw_addr_i, int'(aw_len_i), int'(aw_size_i), aw_burst_i, k);
                    nb.id   = aw_id_i;
                    nb.last = (k == int'(aw_len_i));
                    exp_beats.push_back(nb);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_last.delete();
        log_cyc.delete();
    endtask

    task automatic send_aw(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                           input logic [1:0] bu, input logic [ID_WIDTH-1:0] id);
        int n;
        aw_addr_i = a; aw_len_i = l; aw_size_i = s; aw_burst_i = bu; aw_id_i = id;
        aw_valid_i = 1'b1;
        n = 0;
        @(negedge clk_i);
        while (!aw_ready_o && n < 40) begin
            @(negedge clk_i);
            n++;
        end
        check("aw_accept_timeout", aw_ready_o, 1);
        tick();
        aw_valid_i = 1'b0;
    endtask

    task automatic wait_log(input int n);
        int t;
        t = 0;
        while (log_addr.size() < n && t < 100) begin
            tick();
            t++;
        end
        check("burst_done_timeout", log_addr.size() >= n, 1);
    endtask

    task automatic check_burst(input string name, input int n, input logic [31:0] e0,
                               input logic [31:0] e1, input logic [31:0] e2,
                               input logic [31:0] e3, input bit consec);
        check({name, "_beats"}, log_addr.size(), n);
        for (int k = 0; k < n && k < log_addr.size(); k++) begin
            logic [31:0] e;
            e = (k == 0) ? e0 : (k == 1) ? e1 : (k == 2) ? e2 : e3;
            check($sformatf("%s_addr%0d", name, k), log_addr[k], e);
            check($sformatf("%s_last%0d", name, k), log_last[k], k == n - 1);
            if (consec && k > 0) check($sformatf("%s_gap%0d", name, k), log_cyc[k] - log_cyc[k-1], 1);
        end
    endtask

    task automatic pulse_synch();
        if (synch_pending.size() > 0) begin
            synch_req_i = 1'b1;
            synch_id_i  = synch_pending.pop_front();
        end
        tick();
        synch_req_i = 1'b0;
    endtask

    initial begin
        #1 rst_i = 1'b1;
        tick(); tick(); tick();
        rst_i = 1'b0;
        trans_gnt_i = 1'b1;

        // Single INCR burst, continuous grant, then one response.
        clear_log();
        send_aw(32'h1000, 8'd3, 3'd2, 2'b01, 6'd5);
        wait_log(4);
        check_burst("incr", 4, 32'h1000, 32'h1004, 32'h1008, 32'h100C, 1'b1);
        synch_req_i = 1'b1;
        synch_id_i  = synch_pending.pop_front();
        @(negedge clk_i);
        check("b_latency_before", b_valid_o, 0);
        tick();
        synch_req_i = 1'b0;
        @(negedge clk_i);
        check("b_latency_valid", b_valid_o, 1);
        check("b_latency_id", b_id_o, 5);
        tick();
        b_ready_i = 1'b1;
        tick();

        clear_log();
        send_aw(32'h2008, 8'd3, 3'd2, 2'b10, 6'd1);
        wait_log(4);
        check_burst("wrap", 4, 32'h2008, 32'h200C, 32'h2000, 32'h2004, 1'b1);
        pulse_synch(); tick();

        clear_log();
        send_aw(32'h3000, 8'd2, 3'd2, 2'b00, 6'd2);
        wait_log(3);
        check_burst("fixed", 3, 32'h3000, 32'h3000, 32'h3000, 32'h0, 1'b1);
        pulse_synch(); tick();

        clear_log();
        send_aw(32'h4001, 8'd2, 3'd1, 2'b01, 6'd3);
        wait_log(3);
        check_burst("unaligned", 3, 32'h4001, 32'h4002, 32'h4004, 32'h0, 1'b1);
        pulse_synch(); tick();

        // Grant stall on beat 1.
        clear_log();
        send_aw(32'h1000, 8'd3, 3'd2, 2'b01, 6'd5);
        tick();
        trans_gnt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("stall_req", trans_req_o, 1);
            check("stall_add", trans_add_o, 32'h1004);
            check("stall_id", trans_id_o, 5);
            check("stall_last", trans_last_o, 0);
            tick();
        end
        trans_gnt_i = 1'b1;
        wait_log(4);
        check_burst("stall", 4, 32'h1000, 32'h1004, 32'h1008, 32'h100C, 1'b0);
        if (log_cyc.size() >= 2) check("stall_gap", log_cyc[1] - log_cyc[0], 4);
        pulse_synch(); tick();

        // Outstanding limit and same-cycle push/pop.
        b_ready_i = 1'b0;
        clear_log();
        send_aw(32'h6000, 8'd0, 3'd2, 2'b01, 6'd10);
        wait_log(1);
        send_aw(32'h6100, 8'd0, 3'd2, 2'b01, 6'd11);
        wait_log(2);
        pulse_synch();
        pulse_synch();
        aw_addr_i = 32'h6200; aw_len_i = 8'd1; aw_size_i = 3'd2; aw_burst_i = 2'b01; aw_id_i = 6'd12;
        aw_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("limit_aw_ready", aw_ready_o, 0);
            tick();
        end
        b_ready_i = 1'b1;
        @(negedge clk_i);
        check("limit_b_id", b_id_o, 10);
        check("limit_still_blocked", aw_ready_o, 0);
        tick();
        b_ready_i = 1'b0;
        @(negedge clk_i);
        check("limit_released", aw_ready_o, 1);
        tick();
        aw_valid_i = 1'b0;
        wait_log(4);
        synch_req_i = 1'b1;
        synch_id_i  = synch_pending.pop_front();
        b_ready_i   = 1'b1;
        @(negedge clk_i);
        check("pp_head", b_id_o, 11);
        tick();
        synch_req_i = 1'b0;
        b_ready_i   = 1'b0;
        @(negedge clk_i);
        check("pp_valid", b_valid_o, 1);
        check("pp_id", b_id_o, 12);
        tick();
        b_ready_i = 1'b1;
        tick();
        b_ready_i = 1'b0;
        @(negedge clk_i);
        check("pp_drained", b_valid_o, 0);
        tick();

        // Reset on beat 2 of a len-7 burst with a response pending.
        clear_log();
        send_aw(32'h7000, 8'd0, 3'd2, 2'b01, 6'd20);
        wait_log(1);
        pulse_synch();
        send_aw(32'h5000, 8'd7, 3'd2, 2'b01, 6'd21);
        tick(); tick();
        @(negedge clk_i);
        check("mid_beat2_add", trans_add_o, 32'h5008);
        #1 rst_i = 1'b1;
        #1;
        check("mid_rst_req", trans_req_o, 0);
        check("mid_rst_b_valid", b_valid_o, 0);
        check("mid_rst_aw_ready", aw_ready_o, 0);
        tick(); tick();
        rst_i = 1'b0;
        @(negedge clk_i);
        check("post_rst_aw_ready", aw_ready_o, 1);
        check("post_rst_b_valid", b_valid_o, 0);
        tick();

        // Randomised traffic with one reset in the middle.
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) rst_i = 1'b1;
            if (c == 1502) rst_i = 1'b0;
            if (rst_i) begin
                aw_valid_i  = 1'b0;
                synch_req_i = 1'b0;
            end else begin
                if (!aw_valid_i || hs_pending) begin
                    aw_valid_i = ($urandom_range(0, 2) == 0);
                    aw_size_i  = 3'($urandom_range(0, 2));
                    aw_burst_i = 2'($urandom_range(0, 3));
                    if (aw_burst_i == 2'b10) aw_len_i = 8'((1 << $urandom_range(1, 4)) - 1);
                    else aw_len_i = 8'($urandom_range(0, 15));
                    if ($urandom_range(0, 7) == 0) aw_addr_i = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                    else aw_addr_i = $urandom;
                    aw_id_i = ID_WIDTH'($urandom);
                end
                trans_gnt_i = ($urandom_range(0, 3) != 0);
                b_ready_i   = ($urandom_range(0, 2) != 0);
                if (synch_pending.size() > 0 && $urandom_range(0, 1) == 1) begin
                    synch_req_i = 1'b1;
                    synch_id_i  = synch_pending.pop_front();
                end else begin
                    synch_req_i = 1'b0;
                end
            end
            tick();
        end
        aw_valid_i  = 1'b0;
        synch_req_i = 1'b0;
        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi2mem_wr_cmd_seq.md
# axi2mem_wr_cmd_seq

AXI write-burst command sequencer sitting in front of the TCDM write interface of the axi2mem bridge. It accepts one AW burst at a time and expands it into per-beat word commands (address, ID, last flag) under a req/gnt handshake. It collects the end-of-burst synchronisation pulses returned by the TCDM write interface into a small FIFO and presents them as AXI B responses. The number of bursts accepted but not yet answered on B is bounded, so the response FIFO never overflows.

## Interface
- ID_WIDTH, 6, AXI ID width.
- B_DEPTH, 2, outstanding-burst limit and response FIFO depth (>=1).
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- aw_valid_i  in  1  AW request.
- aw_ready_o  out  1  AW accept.
- aw_addr_i  in  32  burst start byte address.
- aw_len_i  in  8  beats minus one.
- aw_size_i  in  3  log2 bytes per beat; only 0..2 are legal.
- aw_burst_i  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 treated as INCR.
- aw_id_i  in  ID_WIDTH  burst ID.
- trans_req_o  out  1  beat command valid.
- trans_gnt_i  in  1  beat command accepted by the TCDM write interface.
- trans_add_o  out  32  beat byte address.
- trans_id_o  out  ID_WIDTH  burst ID.
- trans_last_o  out  1  final beat of the burst.
- synch_req_i  in  1  single-cycle pulse: a burst's last beat has been committed.
- synch_id_i  in  ID_WIDTH  ID of the committed burst.
- b_valid_o  out  1  write response valid.
- b_ready_i  in  1  write response accept.
- b_id_o  out  ID_WIDTH  response ID.
- b_resp_o  out  2  always 2'b00 (OKAY).

## Operation
- The FSM has two states.
  - IDLE: aw_ready_o = (outstanding < B_DEPTH).
    - On an AW handshake: register addr, len, size, burst and id; clear beat_cnt; increment outstanding; go to BURST.
  - BURST: trans_req_o = 1; aw_ready_o = 0.
    - trans_add_o = cur_addr, trans_id_o = reg_id, trans_last_o = (beat_cnt == reg_len).
    - On trans_gnt_i with last: go to IDLE.
    - On trans_gnt_i without last: beat_cnt += 1 and cur_addr advances.
- Address advance uses inc = 1 << size.
  - FIXED: cur_addr unchanged.
  - INCR: cur_addr = (cur_addr & ~(inc-1)) + inc. An unaligned start is aligned from the second beat on. The 32-bit add wraps modulo 2^32.
  - WRAP: wrap size W = (len+1) << size, with len in {1,3,7,15}. Compute nxt = aligned cur_addr + inc. If (nxt & (W-1)) == 0, cur_addr = nxt - W; otherwise cur_addr = nxt.
  - Illegal len with WRAP: behaviour is undefined and not checked.
- Command fields hold stable while trans_req_o = 1 and trans_gnt_i = 0.
- Response FIFO:
  - Depth B_DEPTH.
  - Push {synch_id_i} whenever synch_req_i = 1.
  - Pop on b_valid_o & b_ready_i.
  - b_valid_o = not empty; b_id_o = head entry.
  - A push and a pop in the same cycle are both performed, and the occupancy is unchanged.
- outstanding counter:
  - Width $clog2(B_DEPTH+1).
  - +1 on an AW handshake, −1 on a B handshake; both in the same cycle leaves it unchanged.
  - A push into a full FIFO cannot occur. Verification asserts this.

## Timing
- Reset (rst_i high, async):
  - State IDLE; outstanding, beat_cnt and FIFO pointers cleared.
  - trans_req_o = 0, trans_last_o = 0, trans_add_o = 0, trans_id_o = 0.
  - b_valid_o = 0, b_id_o = 0, b_resp_o = 0.
  - aw_ready_o is forced 0 while rst_i is high and is 1 in the first cycle after release.
- A reset asserted mid-burst abandons the burst and discards all pending responses.
- Latency:
  - AW handshake in cycle N → first trans_req_o in N+1.
  - With continuous gnt, a burst of len+1 beats occupies cycles N+1..N+1+len.
  - Next aw_ready_o = 1 at the earliest N+2+len, giving one IDLE bubble per burst.
- synch_req_i in cycle M → b_valid_o in M+1. The FIFO is registered and has no fall-through.
- Outputs are driven from registers or simple decode of registered state. There is no combinational path from trans_gnt_i to trans_req_o.

## Test plan
- Single INCR burst: addr 0x1000, len 3, size 2, id 5, gnt held 1.
  - Required: trans_add_o 0x1000, 0x1004, 0x1008, 0x100C in consecutive cycles.
  - Required: trans_last_o only on 0x100C.
  - Then synch_req_i pulse (id 5) → b_valid_o with b_id_o = 5 one cycle later.
- WRAP burst: addr 0x2008, len 3, size 2.
  - Required: addresses 0x2008, 0x200C, 0x2000, 0x2004.
  - Also FIXED len 2 at 0x3000 → three beats at 0x3000.
- Unaligned INCR: addr 0x4001, size 1, len 2.
  - Required: addresses 0x4001, 0x4002, 0x4004.
- Gnt stall: gnt held 0 for 3 cycles on beat 1.
  - Required: trans_add_o, trans_id_o and trans_last_o stable; beat_cnt does not advance.
- Outstanding limit (B_DEPTH 2): two bursts complete with b_ready_i = 0.
  - Required: aw_ready_o = 0 for a third AW.
  - One B handshake → aw_ready_o = 1 next cycle.
  - Same-cycle push and pop keep the occupancy unchanged.
- Reset mid-burst on beat 2 of len 7.
  - Required: trans_req_o = 0 immediately.
  - Required: b_valid_o = 0 with the FIFO empty.
  - Required: aw_ready_o = 1 in the first cycle after release.
